dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single 64-word data memory between two requesters: core load/store port (req0) and program loader/debug port (req1).
- Sits between the core datapath and the synchronous-read data memory.
- One transaction outstanding at a time. Each accepted request gets exactly one response pulse.
- Optional lock lets the loader hold the memory for back-to-back bursts.

Parameters:
- ADDR_W, 6, word-address width (64 words)
- DATA_W, 32, data width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  core request valid
- req0_we  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  word address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  core request accepted this cycle
- req0_rvalid  out  1  core response pulse (read data or write ack)
- req0_rdata  out  DATA_W  read data, valid with req0_rvalid
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as req0, for loader
- req1_lock  in  1  keep grant with req1 after the current transaction
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered, valid 1 cycle after mem_en

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; last_grant=1, so req0 wins the first tie.
  - All outputs 0, including rdata buses.
- States: IDLE, RESP, LOCKED.
- IDLE:
  - The winner's ready = winner's valid (combinational). The loser's ready = 0.
  - On handshake (valid & ready), in the same cycle: mem_en=1, mem_we/mem_addr/mem_wdata taken from the winner. Registered owner=winner. Go to RESP.
- RESP (exactly one cycle):
  - Owner's rvalid=1. Owner's rdata = mem_rdata for reads; rdata = 0 for writes.
  - Both readies = 0. mem_en = 0.
  - last_grant is updated to owner.
  - Next state: LOCKED if owner==1 and req1_lock==1 in this cycle; otherwise IDLE.
- LOCKED:
  - Behaves like IDLE, but only req1 can be granted. req0_ready=0 regardless of req0_valid.
  - If req1_lock drops while no req1 handshake occurs, go to IDLE that cycle with no access.
  - If req1_valid and req1_lock are both high, accept normally and go to RESP.
- Latency and throughput:
  - Request handshake to rvalid: 1 cycle.
  - Peak throughput: 1 transaction per 2 cycles.
- Simultaneous valids in IDLE: resolved by the arbitration policy (see Optional Feature).
- req0_lock does not exist: the core never locks.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- Deasserting valid before ready is permitted; nothing is accepted.
- Reset mid-transaction: the pending response is dropped and no rvalid is issued. Requesters must retry after reset.
- mem_en, mem_we, mem_addr and mem_wdata are 0 whenever no handshake occurs.

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin. On simultaneous valids, the requester != last_grant wins.
- DMEM_ARB_RR_EN undefined: fixed priority, req0 always wins ties. last_grant is still maintained but unused.
- Lock behaviour is identical in both builds.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum (IDLE, RESP, LOCKED)
  - requester ID type (1 bit)
  - default ADDR_W/DATA_W constants
- One sub-module: dmem_arb_pick. Combinational winner select from valid0, valid1, last_grant and lock state. Policy selected by the macro.
- The FSM and response steering stay in the top module.

Test Plan:
- Single core read: preload mem[5]=0xDEADBEEF; req0 read addr 5 → req0_ready same cycle; mem_en=1, mem_addr=5; next cycle req0_rvalid=1, req0_rdata=0xDEADBEEF; req1 outputs stay 0.
- Tie: both valid every cycle, req0 write addr 1 data 0x11, req1 write addr 2 data 0x22:
  - RR build: grants alternate req0, req1, req0.
  - Fixed build: req1 never granted while req0_valid stays high.
- Lock burst: req1_lock=1, req1 writes addr 10..13 back-to-back while req0_valid=1 → four req1 accesses with no req0 grant; after lock drops, req0 is granted within 2 cycles.
- Lock drop while idle: enter LOCKED, deassert req1_lock with req1_valid=0 → IDLE in that cycle, no mem_en; a pending req0 is granted on the next cycle.
- Reset mid-operation: drive reset_n low during RESP of a req0 read → req0_rvalid never pulses; all outputs 0; after release, the first tie goes to req0.
- Write ack: req1 write addr 63 data 0xA5A5A5A5 → mem_we=1, mem_addr=63; next cycle req1_rvalid=1, req1_rdata=0; a later read of addr 63 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Arbitration policy is chosen by the DMEM_ARB_RR_EN macro in dmem_arb_pick.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t ID_CORE   = 1'b0;
    localparam req_id_t ID_LOADER = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two memory requesters.
// DMEM_ARB_RR_EN defined: round-robin on ties; undefined: core (req0) always wins ties.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    input  logic    locked,
    output logic    grant,
    output req_id_t winner
);

`ifndef DMEM_ARB_RR_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Winner and grant qualification
    always_comb begin
        grant  = 1'b0;
        winner = ID_CORE;
        if (locked) begin
            grant  = valid1;
            winner = ID_LOADER;
        end else if (valid0 && valid1) begin
            grant = 1'b1;
`ifdef DMEM_ARB_RR_EN
            winner = ~last_grant;
`else
            winner = ID_CORE;
`endif
        end else if (valid1) begin
            grant  = 1'b1;
            winner = ID_LOADER;
        end else if (valid0) begin
            grant  = 1'b1;
            winner = ID_CORE;
        end else begin
            grant  = 1'b0;
            winner = ID_CORE;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a synchronous-read data memory, one transaction in flight.
// Tie policy set by DMEM_ARB_RR_EN (round-robin) or fixed core priority when undefined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    req_id_t    owner_q, owner_d;
    req_id_t    last_grant_q, last_grant_d;
    logic       op_we_q, op_we_d;
    logic       locked_s;
    logic       pick_grant_s;
    req_id_t    pick_winner_s;

    assign locked_s = (state_q == LOCKED);

    dmem_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .locked     (locked_s),
        .grant      (pick_grant_s),
        .winner     (pick_winner_s)
    );

    // Next-state, memory strobe and response steering
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_we_d      = op_we_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        req0_rvalid  = 1'b0;
        req1_rvalid  = 1'b0;
        req0_rdata   = {DATA_W{1'b0}};
        req1_rdata   = {DATA_W{1'b0}};
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {ADDR_W{1'b0}};
        mem_wdata    = {DATA_W{1'b0}};
        // Outputs are forced low for the whole time reset is asserted
        if (!reset_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, LOCKED: begin
                    if (pick_grant_s) begin
                        if (pick_winner_s == ID_LOADER) begin
                            req1_ready = 1'b1;
                            mem_we     = req1_we;
                            mem_addr   = req1_addr;
                            mem_wdata  = req1_wdata;
                            op_we_d    = req1_we;
                        end else begin
                            req0_ready = 1'b1;
                            mem_we     = req0_we;
                            mem_addr   = req0_addr;
                            mem_wdata  = req0_wdata;
                            op_we_d    = req0_we;
                        end
                        mem_en  = 1'b1;
                        owner_d = pick_winner_s;
                        state_d = RESP;
                    end else if (locked_s && !req1_lock) begin
                        state_d = IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                RESP: begin
                    last_grant_d = owner_q;
                    if (owner_q == ID_LOADER) begin
                        req1_rvalid = 1'b1;
                        req1_rdata  = op_we_q ? {DATA_W{1'b0}} : mem_rdata;
                    end else begin
                        req0_rvalid = 1'b1;
                        req0_rdata  = op_we_q ? {DATA_W{1'b0}} : mem_rdata;
                    end
                    if ((owner_q == ID_LOADER) && req1_lock) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and transaction-owner registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= ID_CORE;
            last_grant_q <= ID_LOADER;
            op_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_we_q      <= op_we_d;
        end
    end

endmodule
